// File: rtl/sdram_uart_pkg.sv
// Constants and types shared by the SDRAM/UART bridge and the command parser.
package sdram_uart_pkg;

    localparam logic [7:0] R = 8'h52;
    localparam logic [7:0] W = 8'h57;
    localparam logic [7:0] D = 8'h44;
    localparam logic [7:0] K = 8'h4B;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 24;

    typedef enum logic {
        RESP_WRITE = 1'b0,
        RESP_READ  = 1'b1
    } resp_type_e;

    typedef struct packed {
        resp_type_e          typ;
        logic [DATA_W-1:0]   data;
    } resp_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND_HDR,
        SEND_HI,
        SEND_LO
    } send_state_e;

endpackage

// File: rtl/resp_fifo.sv
// Response FIFO: two pushes (a before b) and one pop per cycle; acceptance uses pre-pop occupancy.
module resp_fifo
    import sdram_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  push_a,
    input  resp_t data_a,
    input  logic  push_b,
    input  resp_t data_b,
    input  logic  pop,
    output resp_t head_c,
    output logic  empty_c,
    output logic  drop_c
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    resp_t          mem [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [PW-1:0]  b_ptr;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  free;
    logic           acc_a;
    logic           acc_b;
    logic           pop_ok;

    // A lone free slot goes to push_a; push_b then needs a second one.
    always_comb begin
        free    = CW'(DEPTH) - count_q;
        acc_a   = push_a && (free != '0);
        acc_b   = push_b && (free > CW'(acc_a));
        pop_ok  = pop && (count_q != '0);
        b_ptr   = acc_a ? PW'(wr_ptr_q + PW'(1)) : wr_ptr_q;
        drop_c  = (push_a && !acc_a) || (push_b && !acc_b);
        empty_c = (count_q == '0);
        head_c  = mem[rd_ptr_q];
    end

    always_ff @(posedge CLK) begin
        if (acc_a) mem[wr_ptr_q] <= data_a;
        if (acc_b) mem[b_ptr]    <= data_b;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= PW'(wr_ptr_q + PW'(acc_a) + PW'(acc_b));
            rd_ptr_q <= PW'(rd_ptr_q + PW'(pop_ok));
            count_q  <= CW'(count_q + CW'(acc_a) + CW'(acc_b) - CW'(pop_ok));
        end
    end

endmodule

// File: rtl/sdram_to_uart.sv
// Turns SDRAM read/write completions into UART byte responses: 'D' hi lo for reads, 'K' for writes.
module sdram_to_uart
    import sdram_uart_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_stb,
    input  logic              wt_done,
    output logic [width-1:0]  o_data,
    output logic              o_stb,
    input  logic              o_ack,
    input  logic              clr_ovf,
    output logic              overflow,
    output logic              busy
);

    send_state_e state_q;
    send_state_e state_d;
    resp_t       hold_q;
    resp_t       hold_d;
    resp_t       rd_resp;
    resp_t       wt_resp;
    resp_t       head;
    logic        fifo_empty;
    logic        drop;
    logic        pop;

    always_comb begin
        rd_resp = '{typ: RESP_READ,  data: rd_data};
        wt_resp = '{typ: RESP_WRITE, data: '0};
    end

    resp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push_a  (rd_stb),
        .data_a  (rd_resp),
        .push_b  (wt_done),
        .data_b  (wt_resp),
        .pop     (pop),
        .head_c  (head),
        .empty_c (fifo_empty),
        .drop_c  (drop)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Sender: o_stb/o_data decode straight from the registered state and holding register.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        o_stb   = 1'b0;
        o_data  = '0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = head;
                    state_d = SEND_HDR;
                end
            end
            SEND_HDR: begin
                o_stb  = 1'b1;
                o_data = (hold_q.typ == RESP_READ) ? width'(D) : width'(K);
                if (o_ack) state_d = (hold_q.typ == RESP_READ) ? SEND_HI : IDLE;
            end
            SEND_HI: begin
                o_stb  = 1'b1;
                o_data = width'(hold_q.data[15:8]);
                if (o_ack) state_d = SEND_LO;
            end
            SEND_LO: begin
                o_stb  = 1'b1;
                o_data = width'(hold_q.data[7:0]);
                if (o_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky overflow; a drop in the same cycle beats a clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign busy = !fifo_empty || (state_q != IDLE);

endmodule

// File: doc/sdram_to_uart.md
SDRAM_TO_UART -- requirements
Module: sdram_to_uart

Interface
REQ-001 The module SHALL use parameter width, default 8, as the byte width of the transmit stream; only 8 is supported.
REQ-002 The module SHALL use parameter DEPTH, default 4, as the number of response FIFO entries; it must be a power of two, 2..16.
REQ-003 The module SHALL have port CLK, input, 1, system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-005 The module SHALL have port rd_data, input, 16, SDRAM read word, valid while rd_stb=1.
REQ-006 The module SHALL have port rd_stb, input, 1, one-cycle pulse meaning a read completed.
REQ-007 The module SHALL have port wt_done, input, 1, one-cycle pulse meaning a write completed.
REQ-008 The module SHALL have port o_data, output, width, byte to the UART transmitter.
REQ-009 The module SHALL have port o_stb, output, 1, meaning o_data is valid.
REQ-010 The module SHALL have port o_ack, input, 1, meaning the transmitter accepts the byte this cycle.
REQ-011 The module SHALL have port clr_ovf, input, 1, synchronous clear of the overflow flag.
REQ-012 The module SHALL have port overflow, output, 1, sticky flag meaning a response was dropped.
REQ-013 The module SHALL have port busy, output, 1, meaning the FIFO is not empty or a response is being sent.

Function
REQ-014 Each rd_stb SHALL queue a read response {type=READ, data=rd_data}, and each wt_done SHALL queue a write response {type=WRITE, data=0}, into a DEPTH-entry 17-bit FIFO.
REQ-015 If rd_stb and wt_done are high in the same cycle, both SHALL be pushed, read entry first.
REQ-016 Push acceptance SHALL use the occupancy before any same-cycle pop. When only 1 slot is free with two simultaneous pushes, the read SHALL be accepted and the write dropped.
REQ-017 Every dropped push SHALL set overflow on the next edge. overflow SHALL clear only on RST, or on clr_ovf with no same-cycle drop; a drop wins over clr_ovf.
REQ-018 The sender FSM SHALL have the states IDLE, SEND_HDR, SEND_HI and SEND_LO.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into a holding register and go to SEND_HDR. With the FIFO empty it SHALL stay in IDLE.
REQ-020 In SEND_HDR the block SHALL drive o_stb=1 and o_data=8'h44 ('D') for READ or 8'h4B ('K') for WRITE. On o_ack a READ SHALL go to SEND_HI and a WRITE SHALL go to IDLE.
REQ-021 In SEND_HI the block SHALL drive o_stb=1 and o_data=data[15:8]; on o_ack it SHALL go to SEND_LO.
REQ-022 In SEND_LO the block SHALL drive o_stb=1 and o_data=data[7:0]; on o_ack it SHALL go to IDLE.
REQ-023 o_stb SHALL be 0 in IDLE. o_data SHALL hold stable while o_stb=1 and o_ack=0. o_ack while o_stb=0 SHALL be ignored.
REQ-024 Latency SHALL be: a pulse sampled at edge k makes the entry visible after k; the pop happens at k+1; o_stb is high from k+1 (2 cycles pulse-to-strobe with an empty FIFO and the FSM in IDLE).
REQ-025 Responses SHALL be sent strictly in FIFO order with no gaps beyond the single IDLE pop cycle between responses.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH. The count SHALL range 0..DEPTH, with full at count==DEPTH and empty at count==0.
REQ-027 busy SHALL equal (count!=0) | (state!=IDLE), driven combinationally.

Reset
REQ-028 RST SHALL force, asynchronously: state=IDLE, FIFO pointers and count=0, overflow=0, holding register=0.
REQ-029 While in reset the outputs SHALL be o_stb=0, o_data=0, busy=0, overflow=0.
REQ-030 A response in flight at reset SHALL be discarded with no partial byte resumed; after RST falls the first response starts with its header.

Structure
REQ-031 Package sdram_uart_pkg SHALL hold the opcode constants R=8'h52, W=8'h57, D=8'h44, K=8'h4B, the response type encoding (READ=1, WRITE=0), the 16-bit data width and the 24-bit address width, shared with the command parser.
REQ-032 The FIFO SHALL be a separate sub-module resp_fifo (parameter DEPTH, dual push, single pop, async reset). The FSM and output mux SHALL stay in sdram_to_uart.

Verification
REQ-033 The bench SHALL check: rd_stb with rd_data=16'hA55A and o_ack tied 1 -> o_data sequence 44,A5,5A on consecutive strobed cycles, busy then 0.
REQ-034 The bench SHALL check: wt_done alone -> single byte 4B, then IDLE, overflow=0.
REQ-035 The bench SHALL check: rd_stb (16'h1234) and wt_done in the same cycle, o_ack=1 -> 44,12,34,4B in that order.
REQ-036 The bench SHALL check: o_ack held 0 with 6 rd_stb pulses at DEPTH=4 -> one entry in the holding register plus 4 queued, 1 dropped, overflow=1; after releasing o_ack, exactly 5 responses are sent; clr_ovf -> overflow=0.
REQ-037 The bench SHALL check: o_ack stalled 3 cycles in SEND_HI -> o_data stays at the high byte and o_stb stays 1 until the ack.
REQ-038 The bench SHALL check: RST asserted in SEND_LO -> o_stb=0 immediately and FIFO empty; the next rd_stb of 16'h00FF yields 44,00,FF.
